// File: rtl/vga_scroll_top.sv
`default_nettype none
// ============================================================================
// Module      : vga_scroll_top
// Description : VGA video top with internal timing generation, a debounced
//               scroll button and horizontal/vertical scroll offsets that are
//               updated only at the start of vertical blanking. Memory
//               addresses are generated combinationally from the counters and
//               scroll offsets. Sync, blank and RGB are registered once, so
//               they leave the block mutually aligned.
// Ports       : clk         - pixel clock, also forwarded on VGA_CLK
//               rst         - synchronous active-high reset
//               button      - asynchronous push-button, active high
//               dir         - 0: offset increases, 1: offset decreases
//               axis        - 0: horizontal scroll, 1: vertical scroll
//               mem_data    - {R,G,B} read combinationally at mem_*_addr
//               mem_h_addr  - (h_cnt + scroll_h) mod H_ACTIVE
//               mem_v_addr  - (v_cnt + scroll_v) mod V_ACTIVE
//               scroll_h/v  - current scroll offsets
//               VGA_*       - registered video outputs (sync active low)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scroll_top #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int STEP     = 10,
    parameter int DEB_CYC  = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic        dir,
    input  logic        axis,
    input  logic [23:0] mem_data,
    output logic [9:0]  mem_h_addr,
    output logic [8:0]  mem_v_addr,
    output logic [9:0]  scroll_h,
    output logic [8:0]  scroll_v,
    output logic        VGA_CLK,
    output logic        VGA_HSYNC,
    output logic        VGA_VSYNC,
    output logic        VGA_BLANK_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] c_H_LAST   = 12'(c_H_TOT - 1);
    localparam logic [11:0] c_V_LAST   = 12'(c_V_TOT - 1);
    localparam logic [11:0] c_H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] c_V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] c_HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    // Address sums are reduced by at most two subtractions of the active size;
    // that is exact inside the active area, where the address matters.
    localparam logic [12:0] c_H_1A     = 13'(H_ACTIVE);
    localparam logic [12:0] c_H_2A     = 13'(2 * H_ACTIVE);
    localparam logic [12:0] c_V_1A     = 13'(V_ACTIVE);
    localparam logic [12:0] c_V_2A     = 13'(2 * V_ACTIVE);

    // Offset arithmetic is carried one bit wider than the offset itself.
    localparam logic [10:0] c_H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [9:0]  c_V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [10:0] c_STEP_H   = 11'(STEP);
    localparam logic [9:0]  c_STEP_V   = 10'(STEP);

    localparam int                 c_DEB_W    = $clog2(DEB_CYC + 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYC - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [11:0]        r_h_cnt_q,     w_h_cnt_d;
    logic [11:0]        r_v_cnt_q,     w_v_cnt_d;
    logic               r_sync1_q,     r_sync2_q;
    logic [c_DEB_W-1:0] r_deb_cnt_q,   w_deb_cnt_d;
    logic               r_deb_level_q, w_deb_level_d;
    logic [1:0]         r_pending_q,   w_pending_d;
    logic [9:0]         r_scroll_h_q,  w_scroll_h_d;
    logic [8:0]         r_scroll_v_q,  w_scroll_v_d;
    logic               r_hsync_q,     w_hsync_d;
    logic               r_vsync_q,     w_vsync_d;
    logic               r_blank_n_q,   w_blank_n_d;
    logic [23:0]        r_rgb_q,       w_rgb_d;

    logic               w_press;
    logic               w_apply;
    logic [12:0]        w_h_sum;
    logic [12:0]        w_v_sum;
    logic [10:0]        w_h_inc;
    logic [9:0]         w_v_inc;

    // ------------------------------------------------------------------------
    // Video timing counters
    // ------------------------------------------------------------------------
    always_comb begin
        w_h_cnt_d = r_h_cnt_q + 12'd1;
        w_v_cnt_d = r_v_cnt_q;
        if (r_h_cnt_q == c_H_LAST) begin
            w_h_cnt_d = 12'd0;
            if (r_v_cnt_q == c_V_LAST) begin
                w_v_cnt_d = 12'd0;
            end else begin
                w_v_cnt_d = r_v_cnt_q + 12'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Button debounce: count consecutive cycles where the synchronised input
    // disagrees with the accepted level; any agreement clears the count.
    // ------------------------------------------------------------------------
    always_comb begin
        w_deb_cnt_d   = '0;
        w_deb_level_d = r_deb_level_q;
        w_press       = 1'b0;
        if (r_sync2_q != r_deb_level_q) begin
            if (r_deb_cnt_q == c_DEB_LAST) begin
                w_deb_level_d = r_sync2_q;
                w_press       = r_sync2_q;
            end else begin
                w_deb_cnt_d = r_deb_cnt_q + c_DEB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pending presses and the once-per-frame apply event at start of vblank
    // ------------------------------------------------------------------------
    assign w_apply = (r_h_cnt_q == 12'd0) && (r_v_cnt_q == c_V_ACT) &&
                     (r_pending_q != 2'd0);

    always_comb begin
        w_pending_d = r_pending_q;
        if (w_press && !w_apply) begin
            if (r_pending_q != 2'd3) begin
                w_pending_d = r_pending_q + 2'd1;
            end
        end else if (!w_press && w_apply) begin
            w_pending_d = r_pending_q - 2'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Scroll offsets, wrapped modulo the active size in either direction
    // ------------------------------------------------------------------------
    always_comb begin
        w_scroll_h_d = r_scroll_h_q;
        w_scroll_v_d = r_scroll_v_q;
        w_h_inc      = {1'b0, r_scroll_h_q} + c_STEP_H;
        w_v_inc      = {1'b0, r_scroll_v_q} + c_STEP_V;
        if (w_apply) begin
            if (!axis) begin
                if (!dir) begin
                    w_scroll_h_d = (w_h_inc >= c_H_ACT_W) ? 10'(w_h_inc - c_H_ACT_W)
                                                          : 10'(w_h_inc);
                end else if ({1'b0, r_scroll_h_q} < c_STEP_H) begin
                    w_scroll_h_d = 10'({1'b0, r_scroll_h_q} + c_H_ACT_W - c_STEP_H);
                end else begin
                    w_scroll_h_d = 10'({1'b0, r_scroll_h_q} - c_STEP_H);
                end
            end else begin
                if (!dir) begin
                    w_scroll_v_d = (w_v_inc >= c_V_ACT_W) ? 9'(w_v_inc - c_V_ACT_W)
                                                          : 9'(w_v_inc);
                end else if ({1'b0, r_scroll_v_q} < c_STEP_V) begin
                    w_scroll_v_d = 9'({1'b0, r_scroll_v_q} + c_V_ACT_W - c_STEP_V);
                end else begin
                    w_scroll_v_d = 9'({1'b0, r_scroll_v_q} - c_STEP_V);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory addresses (combinational)
    // ------------------------------------------------------------------------
    always_comb begin
        w_h_sum = {1'b0, r_h_cnt_q} + 13'(r_scroll_h_q);
        w_v_sum = {1'b0, r_v_cnt_q} + 13'(r_scroll_v_q);
        if (w_h_sum >= c_H_2A) begin
            mem_h_addr = 10'(w_h_sum - c_H_2A);
        end else if (w_h_sum >= c_H_1A) begin
            mem_h_addr = 10'(w_h_sum - c_H_1A);
        end else begin
            mem_h_addr = 10'(w_h_sum);
        end
        if (w_v_sum >= c_V_2A) begin
            mem_v_addr = 9'(w_v_sum - c_V_2A);
        end else if (w_v_sum >= c_V_1A) begin
            mem_v_addr = 9'(w_v_sum - c_V_1A);
        end else begin
            mem_v_addr = 9'(w_v_sum);
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: one register for sync, blank and colour
    // ------------------------------------------------------------------------
    always_comb begin
        w_hsync_d   = !((r_h_cnt_q >= c_HS_START) && (r_h_cnt_q < c_HS_END));
        w_vsync_d   = !((r_v_cnt_q >= c_VS_START) && (r_v_cnt_q < c_VS_END));
        w_blank_n_d = (r_h_cnt_q < c_H_ACT) && (r_v_cnt_q < c_V_ACT);
        w_rgb_d     = w_blank_n_d ? mem_data : 24'd0;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt_q     <= 12'd0;
            r_v_cnt_q     <= 12'd0;
            r_sync1_q     <= 1'b0;
            r_sync2_q     <= 1'b0;
            r_deb_cnt_q   <= '0;
            r_deb_level_q <= 1'b0;
            r_pending_q   <= 2'd0;
            r_scroll_h_q  <= 10'd0;
            r_scroll_v_q  <= 9'd0;
            r_hsync_q     <= 1'b1;
            r_vsync_q     <= 1'b1;
            r_blank_n_q   <= 1'b0;
            r_rgb_q       <= 24'd0;
        end else begin
            r_h_cnt_q     <= w_h_cnt_d;
            r_v_cnt_q     <= w_v_cnt_d;
            r_sync1_q     <= button;
            r_sync2_q     <= r_sync1_q;
            r_deb_cnt_q   <= w_deb_cnt_d;
            r_deb_level_q <= w_deb_level_d;
            r_pending_q   <= w_pending_d;
            r_scroll_h_q  <= w_scroll_h_d;
            r_scroll_v_q  <= w_scroll_v_d;
            r_hsync_q     <= w_hsync_d;
            r_vsync_q     <= w_vsync_d;
            r_blank_n_q   <= w_blank_n_d;
            r_rgb_q       <= w_rgb_d;
        end
    end

    assign scroll_h    = r_scroll_h_q;
    assign scroll_v    = r_scroll_v_q;
    assign VGA_CLK     = clk;
    assign VGA_HSYNC   = r_hsync_q;
    assign VGA_VSYNC   = r_vsync_q;
    assign VGA_BLANK_N = r_blank_n_q;
    assign VGA_R       = r_rgb_q[23:16];
    assign VGA_G       = r_rgb_q[15:8];
    assign VGA_B       = r_rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_scroll_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scroll_top
// Description : Directed testbench for vga_scroll_top using a small timing
//               (H 8/1/2/1, V 6/1/1/1), STEP=3 and DEB_CYC=4. Video memory
//               returns its own address as {5'b0, h_addr, v_addr}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scroll_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        button;
    logic        dir;
    logic        axis;
    logic [23:0] mem_data;
    logic [9:0]  mem_h_addr;
    logic [8:0]  mem_v_addr;
    logic [9:0]  scroll_h;
    logic [8:0]  scroll_v;
    logic        vga_clk;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    vga_scroll_top #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .STEP     (3), .DEB_CYC (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .dir         (dir),
        .axis        (axis),
        .mem_data    (mem_data),
        .mem_h_addr  (mem_h_addr),
        .mem_v_addr  (mem_v_addr),
        .scroll_h    (scroll_h),
        .scroll_v    (scroll_v),
        .VGA_CLK     (vga_clk),
        .VGA_HSYNC   (vga_hsync),
        .VGA_VSYNC   (vga_vsync),
        .VGA_BLANK_N (vga_blank_n),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b)
    );

    always #5 clk = ~clk;

    // Memory returns the address it is given
    assign mem_data = {5'b0, mem_h_addr, mem_v_addr};

    // Cycle index since the last reset edge; cycle 0 has h=0, v=0
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        while (cyc != target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, target);
        end
    endtask

    task automatic press(input int hi, input int lo);
        button = 1'b1;
        repeat (hi) @(negedge clk);
        button = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Whole-frame counters over the first two frames
    logic count_en = 1'b0;
    int   hs_low   = 0;
    int   vs_low   = 0;
    int   bl_high  = 0;
    always @(negedge clk) begin
        if (count_en && cyc >= 1 && cyc <= 216) begin
            if (!vga_hsync)  hs_low  <= hs_low + 1;
            if (!vga_vsync)  vs_low  <= vs_low + 1;
            if (vga_blank_n) bl_high <= bl_high + 1;
        end
    end

    typedef struct {
        int         t;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [23:0] rgb;
        logic [9:0] ha;
        logic [8:0] va;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Checked at cycle t: registered outputs show cycle t-1, addresses show t
        tbl[0]  = '{1,   1'b1, 1'b1, 1'b1, 24'h000000, 10'd1, 9'd0};
        tbl[1]  = '{8,   1'b1, 1'b1, 1'b1, 24'h000E00, 10'd0, 9'd0};
        tbl[2]  = '{9,   1'b1, 1'b1, 1'b0, 24'h000000, 10'd1, 9'd0};
        tbl[3]  = '{10,  1'b0, 1'b1, 1'b0, 24'h000000, 10'd2, 9'd0};
        tbl[4]  = '{11,  1'b0, 1'b1, 1'b0, 24'h000000, 10'd3, 9'd0};
        tbl[5]  = '{12,  1'b1, 1'b1, 1'b0, 24'h000000, 10'd0, 9'd1};
        tbl[6]  = '{13,  1'b1, 1'b1, 1'b1, 24'h000001, 10'd1, 9'd1};
        tbl[7]  = '{67,  1'b1, 1'b1, 1'b1, 24'h000C05, 10'd7, 9'd5};
        tbl[8]  = '{70,  1'b0, 1'b1, 1'b0, 24'h000000, 10'd2, 9'd5};
        tbl[9]  = '{73,  1'b1, 1'b1, 1'b0, 24'h000000, 10'd1, 9'd0};
        tbl[10] = '{85,  1'b1, 1'b0, 1'b0, 24'h000000, 10'd1, 9'd1};
        tbl[11] = '{95,  1'b0, 1'b0, 1'b0, 24'h000000, 10'd3, 9'd1};
        tbl[12] = '{97,  1'b1, 1'b1, 1'b0, 24'h000000, 10'd1, 9'd2};
        tbl[13] = '{109, 1'b1, 1'b1, 1'b1, 24'h000000, 10'd1, 9'd0};

        rst = 1'b1; button = 1'b0; dir = 1'b0; axis = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_hsync", 32'(vga_hsync), 32'd1);
        chk("rst_vsync", 32'(vga_vsync), 32'd1);
        chk("rst_blank", 32'(vga_blank_n), 32'd0);
        chk("rst_rgb",   32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_scroll_h", 32'(scroll_h), 32'd0);

        // 1. Timing over two frames
        count_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            wait_until(tbl[i].t);
            chk("tbl_hsync", 32'(vga_hsync),   32'(tbl[i].hs));
            chk("tbl_vsync", 32'(vga_vsync),   32'(tbl[i].vs));
            chk("tbl_blank", 32'(vga_blank_n), 32'(tbl[i].bl));
            chk("tbl_rgb",   32'({vga_r, vga_g, vga_b}), 32'(tbl[i].rgb));
            chk("tbl_haddr", 32'(mem_h_addr),  32'(tbl[i].ha));
            chk("tbl_vaddr", 32'(mem_v_addr),  32'(tbl[i].va));
        end
        wait_until(217);
        count_en = 1'b0;
        chk("hsync_low_cycles", 32'(hs_low),  32'd36);
        chk("vsync_low_cycles", 32'(vs_low),  32'd24);
        chk("blank_high_cycles", 32'(bl_high), 32'd96);

        // 2. Debounce: 3-clk pulse ignored, 5-clk pulse is one press
        wait_until(220);
        press(3, 6);
        press(5, 8);
        wait_until(288);
        chk("t2_before_apply", 32'(scroll_h), 32'd0);
        wait_until(289);
        chk("t2_after_apply", 32'(scroll_h), 32'd3);
        wait_until(397);
        chk("t2_single_press", 32'(scroll_h), 32'd3);

        // 3. Wrap upward then downward
        wait_until(400);
        press(6, 6);
        wait_until(505);
        chk("t3_to_6", 32'(scroll_h), 32'd6);
        wait_until(510);
        press(6, 6);
        wait_until(613);
        chk("t3_wrap_up", 32'(scroll_h), 32'd1);
        dir = 1'b1;
        wait_until(620);
        press(6, 6);
        press(6, 6);
        wait_until(721);
        chk("t3_wrap_down", 32'(scroll_h), 32'd6);
        wait_until(829);
        chk("t3_down_again", 32'(scroll_h), 32'd3);
        wait_until(937);
        chk("t3_stopped", 32'(scroll_h), 32'd3);

        // 4. Four presses in one frame saturate at three applies
        dir = 1'b0;
        wait_until(940);
        repeat (4) press(6, 6);
        wait_until(1045);
        chk("t4_apply1", 32'(scroll_h), 32'd6);
        wait_until(1153);
        chk("t4_apply2", 32'(scroll_h), 32'd1);
        wait_until(1261);
        chk("t4_apply3", 32'(scroll_h), 32'd4);
        wait_until(1369);
        chk("t4_saturated", 32'(scroll_h), 32'd4);

        // 5. Vertical scroll downward with wrap
        axis = 1'b1;
        dir  = 1'b1;
        wait_until(1380);
        press(6, 6);
        wait_until(1477);
        chk("t5_scroll_v", 32'(scroll_v), 32'd3);
        chk("t5_scroll_h_held", 32'(scroll_h), 32'd4);
        wait_until(1513);
        chk("t5_pixel00_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000803);
        chk("t5_pixel00_blank", 32'(vga_blank_n), 32'd1);
        chk("t5_haddr", 32'(mem_h_addr), 32'd5);
        chk("t5_vaddr", 32'(mem_v_addr), 32'd3);

        // 6. Mid-line reset with pending presses
        axis = 1'b0;
        dir  = 1'b0;
        wait_until(1520);
        repeat (3) press(6, 6);
        wait_until(1585);
        chk("t6_step1", 32'(scroll_h), 32'd7);
        wait_until(1801);
        chk("t6_scroll_h5", 32'(scroll_h), 32'd5);
        wait_until(1810);
        press(6, 6);
        press(6, 6);
        wait_until(1850);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_scroll_h", 32'(scroll_h), 32'd0);
        chk("t6_rst_scroll_v", 32'(scroll_v), 32'd0);
        chk("t6_rst_hsync",   32'(vga_hsync), 32'd1);
        chk("t6_rst_vsync",   32'(vga_vsync), 32'd1);
        chk("t6_rst_blank",   32'(vga_blank_n), 32'd0);
        chk("t6_rst_rgb",     32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("t6_rst_haddr",   32'(mem_h_addr), 32'd0);
        chk("t6_rst_vaddr",   32'(mem_v_addr), 32'd0);
        wait_until(73);
        chk("t6_no_apply1", 32'(scroll_h), 32'd0);
        wait_until(181);
        chk("t6_no_apply2", 32'(scroll_h), 32'd0);
        chk("t6_no_apply_v", 32'(scroll_v), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
